// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response encodings and the traffic generator FSM state type.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FIN
  } tg_state_e;

endpackage

// File: rtl/axi_lite_traffic_gen_if.sv
// AXI4-Lite bus bundle; master drives requests/payloads, slave drives readies/responses.
interface axi_lite_traffic_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_tg_watchdog.sv
// Handshake wait counter: counts while start is high, clear restarts it; expired once
// TIMEOUT_CYC wait cycles have elapsed without a clear.
module axi_tg_watchdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q >= CNT_W'(TIMEOUT_CYC));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (start && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_lite_traffic_gen.sv
// AXI4-Lite traffic generator: writes SEED^i to NUM_WORDS words, reads back and counts errors.
// Registered outputs, valids held until handshake; AXI_TG_STRB_EN adds a byte-strobe write pass.
module axi_lite_traffic_gen
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_WORDS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [31:0]           SEED        = 32'hDEADBEEF,
  parameter int                    TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  axi_lite_traffic_gen_if.master m_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] i);
    return BASE_ADDR + ADDR_WIDTH'(i) * ADDR_WIDTH'(STRB_W);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pat_of(input logic [IDX_W-1:0] i);
    return DATA_WIDTH'(SEED) ^ DATA_WIDTH'(i);
  endfunction

`ifdef AXI_TG_STRB_EN
  function automatic int unsigned byte_sel(input logic [IDX_W-1:0] i);
    return 32'(i) % 32'(STRB_W);
  endfunction

  function automatic logic [STRB_W-1:0] strb_of(input logic [IDX_W-1:0] i);
    return STRB_W'(1) << byte_sel(i);
  endfunction

  // Memory holds pat(i) from the first pass with one byte overwritten by ~pat(i).
  function automatic logic [DATA_WIDTH-1:0] exp_of(input logic [IDX_W-1:0] i);
    logic [DATA_WIDTH-1:0] p;
    int unsigned           b;
    p = pat_of(i);
    b = byte_sel(i);
    p[b*8 +: 8] = ~p[b*8 +: 8];
    return p;
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] exp_of(input logic [IDX_W-1:0] i);
    return pat_of(i);
  endfunction
`endif

  tg_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
`ifdef AXI_TG_STRB_EN
  logic                  strb_phase_q, strb_phase_d;
`endif
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;

  logic                  aw_hs, w_hs, wd_run, wd_clear, wd_expired;
  logic                  load_wr, load_rd, fin_enter, err_evt;
  logic [ADDR_WIDTH-1:0] err_addr;

  axi_tg_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (wd_run),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
`ifdef AXI_TG_STRB_EN
    strb_phase_d = strb_phase_q;
`endif
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    aw_hs       = awvalid_q && m_axi.awready;
    w_hs        = wvalid_q && m_axi.wready;
    wd_run      = 1'b0;
    wd_clear    = 1'b0;
    load_wr     = 1'b0;
    load_rd     = 1'b0;
    fin_enter   = 1'b0;
    err_evt     = 1'b0;
    err_addr    = '0;

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d     = WR_REQ;
          idx_d       = '0;
`ifdef AXI_TG_STRB_EN
          strb_phase_d = 1'b0;
`endif
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          err_count_d = '0;
          first_err_d = '0;
          load_wr     = 1'b1;
          wd_clear    = 1'b1;
        end
      end
      WR_REQ: begin
        wd_run = 1'b1;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_hs || w_hs) wd_clear = 1'b1;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        wd_run = 1'b1;
        if (m_axi.bvalid) begin
          bready_d = 1'b0;
          wd_clear = 1'b1;
          if (m_axi.bresp != RESP_OKAY) begin
            err_evt  = 1'b1;
            err_addr = awaddr_q;
          end
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            load_wr = 1'b1;
            state_d = WR_REQ;
          end
`ifdef AXI_TG_STRB_EN
          else if (!strb_phase_q) begin
            idx_d        = '0;
            strb_phase_d = 1'b1;
            load_wr      = 1'b1;
            state_d      = WR_REQ;
          end
`endif
          else begin
            idx_d   = '0;
            load_rd = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        wd_run = 1'b1;
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          wd_clear  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        wd_run = 1'b1;
        if (m_axi.rvalid) begin
          rready_d = 1'b0;
          wd_clear = 1'b1;
          if (m_axi.rresp != RESP_OKAY || m_axi.rdata != exp_of(idx_q)) begin
            err_evt  = 1'b1;
            err_addr = araddr_q;
          end
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            load_rd = 1'b1;
            state_d = RD_REQ;
          end else begin
            fin_enter = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A handshake landing in the expiry cycle still wins over the timeout.
    if (wd_run && wd_expired && !wd_clear) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      load_wr   = 1'b0;
      load_rd   = 1'b0;
      timeout_d = 1'b1;
      err_evt   = 1'b1;
      err_addr  = (state_q == RD_REQ || state_q == RD_RESP) ? araddr_q : awaddr_q;
      fin_enter = 1'b1;
    end

    if (load_wr) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = addr_of(idx_d);
      wdata_d   = pat_of(idx_d);
      wstrb_d   = '1;
`ifdef AXI_TG_STRB_EN
      if (strb_phase_d) begin
        wdata_d = ~pat_of(idx_d);
        wstrb_d = strb_of(idx_d);
      end
`endif
    end

    if (load_rd) begin
      arvalid_d = 1'b1;
      araddr_d  = addr_of(idx_d);
    end

    if (err_evt) begin
      if (err_count_q == '0)       first_err_d = err_addr;
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    end

    if (fin_enter) begin
      state_d = FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_count_d == '0) && !timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
`ifdef AXI_TG_STRB_EN
      strb_phase_q <= 1'b0;
`endif
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
`ifdef AXI_TG_STRB_EN
      strb_phase_q <= strb_phase_d;
`endif
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_traffic_gen.sv
// Directed bench for axi_lite_traffic_gen with a small AXI4-Lite memory slave and fault knobs.
module tb_axi_lite_traffic_gen;
  import axi_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int TO = 16;
`ifdef AXI_TG_STRB_EN
  localparam int WR_PASSES = 2;
`else
  localparam int WR_PASSES = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  axi_lite_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  axi_lite_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW),
    .BASE_ADDR(32'h0), .SEED(32'hDEADBEEF), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
    .m_axi(ifc.master)
  );

  always #5 clk = ~clk;

  // Memory slave: one outstanding write and read, responses one cycle after capture.
  logic [31:0] mem [0:1023];
  logic        blk_aw, flip_bit, bresp_err;
  logic        aw_got, w_got, ar_got, s_bvalid, s_rvalid;
  logic [31:0] aw_a, w_d, ar_a, s_rdata, merge;
  logic [3:0]  w_s;
  logic [1:0]  s_bresp;
  logic [31:0] wa_q[$], wd_q[$], rd_q[$];
  logic [3:0]  ws_q[$];

  assign ifc.awready = !blk_aw && !aw_got;
  assign ifc.wready  = !w_got;
  assign ifc.arready = !ar_got;
  assign ifc.bvalid  = s_bvalid;
  assign ifc.bresp   = s_bresp;
  assign ifc.rvalid  = s_rvalid;
  assign ifc.rdata   = s_rdata;
  assign ifc.rresp   = RESP_OKAY;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= RESP_OKAY; s_rdata <= '0;
    end else begin
      if (ifc.awvalid && ifc.awready) begin
        aw_got <= 1'b1; aw_a <= ifc.awaddr; wa_q.push_back(ifc.awaddr);
      end
      if (ifc.wvalid && ifc.wready) begin
        w_got <= 1'b1; w_d <= ifc.wdata; w_s <= ifc.wstrb;
        wd_q.push_back(ifc.wdata); ws_q.push_back(ifc.wstrb);
      end
      if (aw_got && w_got && !s_bvalid) begin
        merge = mem[aw_a[11:2]];
        for (int b = 0; b < 4; b++) if (w_s[b]) merge[b*8 +: 8] = w_d[b*8 +: 8];
        mem[aw_a[11:2]] = merge;
        s_bvalid <= 1'b1;
        s_bresp  <= bresp_err ? RESP_SLVERR : RESP_OKAY;
        aw_got   <= 1'b0; w_got <= 1'b0;
      end
      if (s_bvalid && ifc.bready) s_bvalid <= 1'b0;
      if (ifc.arvalid && ifc.arready) begin ar_got <= 1'b1; ar_a <= ifc.araddr; end
      if (ar_got && !s_rvalid) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[ar_a[11:2]] ^ {31'b0, (flip_bit && ar_a == 32'h8)};
        ar_got   <= 1'b0;
      end
      if (s_rvalid && ifc.rready) begin s_rvalid <= 1'b0; rd_q.push_back(s_rdata); end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); ws_q.delete(); rd_q.delete();
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int cyc, n;
    logic [31:0] exp_rd;
    rst = 1'b1; start = 1'b0; blk_aw = 1'b0; flip_bit = 1'b0; bresp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);       chk("rst_timeout", timeout, 0);
    chk("rst_err", err_count, 0);   chk("rst_first", first_err_addr, 0);
    chk("rst_awvalid", ifc.awvalid, 0); chk("rst_wvalid", ifc.wvalid, 0);
    chk("rst_arvalid", ifc.arvalid, 0); chk("rst_bready", ifc.bready, 0);
    chk("rst_rready", ifc.rready, 0);   chk("rst_wstrb", ifc.wstrb, 4'hF);
    chk("rst_awaddr", ifc.awaddr, 0);   chk("rst_wdata", ifc.wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean pass.
    clear_logs();
    kick();
    chk("a_busy", busy, 1);
    wait_done(400, cyc);
    chk("a_done", done, 1); chk("a_pass", pass, 1); chk("a_err", err_count, 0);
    chk("a_timeout", timeout, 0); chk("a_busy_fin", busy, 0);
    chk("a_nwr", wa_q.size(), NW * WR_PASSES); chk("a_nrd", rd_q.size(), NW);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("a_waddr%0d", i), wa_q[i], 32'(i * 4));
      chk($sformatf("a_wdata%0d", i), wd_q[i], 32'hDEADBEEF ^ 32'(i));
      chk($sformatf("a_wstrb%0d", i), ws_q[i], 4'hF);
      chk($sformatf("a_araddr_rd%0d", i), rd_q[i] !== 32'bx, 1);
    end
`ifdef AXI_TG_STRB_EN
    chk("strb_wstrb4", ws_q[4], 4'b0001); chk("strb_wdata4", wd_q[4], 32'h21524110);
    chk("strb_wstrb5", ws_q[5], 4'b0010); chk("strb_wdata5", wd_q[5], 32'h21524111);
    exp_rd = 32'hDEAD41EE;
`else
    exp_rd = 32'hDEADBEEE;
`endif
    chk("a_rdata1", rd_q[1], exp_rd);

    // Read-data corruption at 0x8, started straight from FIN.
    flip_bit = 1'b1;
    kick();
    wait_done(400, cyc);
    chk("b_done", done, 1); chk("b_err", err_count, 1);
    chk("b_first", first_err_addr, 32'h8); chk("b_pass", pass, 0);
    flip_bit = 1'b0;

    // SLVERR on every write response.
    bresp_err = 1'b1;
    kick();
    wait_done(400, cyc);
    chk("c_done", done, 1); chk("c_err", err_count, NW * WR_PASSES);
    chk("c_first", first_err_addr, 0); chk("c_pass", pass, 0);
    bresp_err = 1'b0;

    // Write address channel never ready.
    blk_aw = 1'b1;
    kick();
    wait_done(40, cyc);
    chk("d_done", done, 1); chk("d_timeout", timeout, 1);
    chk("d_err", err_count, 1); chk("d_pass", pass, 0);
    chk("d_within20", cyc <= 20, 1);
    chk("d_valids", {ifc.awvalid, ifc.wvalid, ifc.arvalid}, 0);
    blk_aw = 1'b0;
    do_reset();
    chk("d_rst_done", done, 0); chk("d_rst_timeout", timeout, 0);

    // Reset in the middle of the first read response.
    kick();
    n = 0;
    while (!ifc.rready && n < 200) begin @(posedge clk); #1; n++; end
    chk("e_saw_rdresp", ifc.rready, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("e_rst_busy", busy, 0); chk("e_rst_rready", ifc.rready, 0);
    chk("e_rst_arvalid", ifc.arvalid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    kick();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("e_busy_ignored", busy, 1);
    wait_done(400, cyc);
    chk("e_done", done, 1); chk("e_pass", pass, 1); chk("e_err", err_count, 0);
    chk("e_nwr", wa_q.size(), NW * WR_PASSES); chk("e_nrd", rd_q.size(), NW);
    chk("e_rdata1", rd_q[1], exp_rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
